// File: rtl/branch_condition_pkg.sv
// Shared condition-code definitions and evaluation for the branch condition path.
package branch_condition_pkg;

    // Condition codes, shared with the instruction decoder.
    typedef enum logic [2:0] {
        COND_NEVER  = 3'b000,
        COND_EQ     = 3'b001,
        COND_LT     = 3'b010,
        COND_LE     = 3'b011,
        COND_ALWAYS = 3'b100,
        COND_NE     = 3'b101,
        COND_GT     = 3'b110,
        COND_GE     = 3'b111
    } cond_opcode_t;

    // Output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Resolve a condition code against the zero (z) and less-than (l) flags.
    function automatic logic cond_eval(input cond_opcode_t opcode, input logic z, input logic l);
        logic result;
        result = 1'b0;
        case (opcode)
            COND_NEVER:  result = 1'b0;
            COND_EQ:     result = z;
            COND_LT:     result = l;
            COND_LE:     result = l | z;
            COND_ALWAYS: result = 1'b1;
            COND_NE:     result = ~z;
            COND_GT:     result = ~(l | z);
            COND_GE:     result = ~l;
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_flag_compare.sv
// Combinational zero/less-than comparison of two operands, signed or unsigned.
module branch_flag_compare #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cmp_signed,
    output logic             zero_c,
    output logic             less_c
);

    // Equality and ordering within WIDTH bits; no widening of the operands.
    always_comb begin
        zero_c = (operand_a == operand_b);
        if (cmp_signed) begin
            less_c = ($signed(operand_a) < $signed(operand_b));
        end else begin
            less_c = (operand_a < operand_b);
        end
    end

endmodule

// File: rtl/branch_condition_unit.sv
// Registered branch condition resolver: flag capture, valid/ready request
// handshake, one-entry response buffer and saturating taken-branch counter.
module branch_condition_unit #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned BYPASS      = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flags_we,
    input  logic [WIDTH-1:0]       operand_a,
    input  logic [WIDTH-1:0]       operand_b,
    input  logic                   cmp_signed,
    input  logic                   req_valid,
    input  logic [2:0]             req_opcode,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic                   resp_taken,
    input  logic                   resp_ready,
    output logic                   flags_valid,
    output logic [COUNT_WIDTH-1:0] taken_count
);
    import branch_condition_pkg::*;

    localparam bit                     USE_BYPASS = (BYPASS != 0);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    logic       cmp_zero_c;
    logic       cmp_less_c;
    logic       flag_z;
    logic       flag_l;
    logic       bypass_c;
    logic       eff_z_c;
    logic       eff_l_c;
    logic       eff_valid_c;
    logic       needs_flags_c;
    logic       accept_c;
    logic       decision_c;
    buf_state_t state_q;
    buf_state_t state_d;

    // Single comparator feeds both the flag register and the bypass path.
    branch_flag_compare #(
        .WIDTH(WIDTH)
    ) u_flag_compare (
        .operand_a (operand_a),
        .operand_b (operand_b),
        .cmp_signed(cmp_signed),
        .zero_c    (cmp_zero_c),
        .less_c    (cmp_less_c)
    );

    // Flag register, loaded on flags_we.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flag_z      <= 1'b0;
            flag_l      <= 1'b0;
            flags_valid <= 1'b0;
        end else if (flags_we) begin
            flag_z      <= cmp_zero_c;
            flag_l      <= cmp_less_c;
            flags_valid <= 1'b1;
        end
    end

    // Effective flags, handshake and decision for the current request.
    always_comb begin
        bypass_c      = USE_BYPASS && flags_we;
        eff_z_c       = bypass_c ? cmp_zero_c : flag_z;
        eff_l_c       = bypass_c ? cmp_less_c : flag_l;
        eff_valid_c   = bypass_c || flags_valid;
        needs_flags_c = (req_opcode[1:0] != 2'b00);
        req_ready     = (!needs_flags_c || eff_valid_c) && (!resp_valid || resp_ready);
        accept_c      = req_valid && req_ready;
        decision_c    = cond_eval(cond_opcode_t'(req_opcode), eff_z_c, eff_l_c);
    end

    // Buffer state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer next state: an acceptance always (re)fills, a drain alone empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: begin
                if (accept_c) begin
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (!accept_c && resp_ready) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    assign resp_valid = (state_q == BUF_FULL);

    // Buffered decision; held until a new request is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_taken <= 1'b0;
        end else if (accept_c) begin
            resp_taken <= decision_c;
        end
    end

    // Saturating count of taken decisions loaded into the buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taken_count <= '0;
        end else if (accept_c && decision_c && (taken_count != COUNT_MAX)) begin
            taken_count <= taken_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_condition_unit.sv
// Bench for branch_condition_unit: three configurations share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_branch_condition_unit;

    localparam logic [2:0] OP_NEVER  = 3'b000;
    localparam logic [2:0] OP_EQ     = 3'b001;
    localparam logic [2:0] OP_LT     = 3'b010;
    localparam logic [2:0] OP_LE     = 3'b011;
    localparam logic [2:0] OP_ALWAYS = 3'b100;
    localparam logic [2:0] OP_NE     = 3'b101;
    localparam logic [2:0] OP_GT     = 3'b110;
    localparam logic [2:0] OP_GE     = 3'b111;

    logic       clock = 1'b0;
    logic       reset;
    logic       flags_we;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       cmp_signed;
    logic       req_valid;
    logic [2:0] req_opcode;
    logic       resp_ready;

    logic [2:0]  rr;
    logic [2:0]  rv;
    logic [2:0]  rt;
    logic [2:0]  fv;
    logic [15:0] tc0;
    logic [15:0] tc1;
    logic [1:0]  tc2;
    logic [15:0] tcv [3];

    assign tcv[0] = tc0;
    assign tcv[1] = tc1;
    assign tcv[2] = {14'd0, tc2};

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // Instance 0: bypass on, wide counter.
    branch_condition_unit #(.WIDTH(8), .COUNT_WIDTH(16), .BYPASS(1)) dut_byp (
        .clock(clock), .reset(reset), .flags_we(flags_we),
        .operand_a(operand_a), .operand_b(operand_b), .cmp_signed(cmp_signed),
        .req_valid(req_valid), .req_opcode(req_opcode), .req_ready(rr[0]),
        .resp_valid(rv[0]), .resp_taken(rt[0]), .resp_ready(resp_ready),
        .flags_valid(fv[0]), .taken_count(tc0)
    );

    // Instance 1: bypass off.
    branch_condition_unit #(.WIDTH(8), .COUNT_WIDTH(16), .BYPASS(0)) dut_nobyp (
        .clock(clock), .reset(reset), .flags_we(flags_we),
        .operand_a(operand_a), .operand_b(operand_b), .cmp_signed(cmp_signed),
        .req_valid(req_valid), .req_opcode(req_opcode), .req_ready(rr[1]),
        .resp_valid(rv[1]), .resp_taken(rt[1]), .resp_ready(resp_ready),
        .flags_valid(fv[1]), .taken_count(tc1)
    );

    // Instance 2: two-bit counter to exercise saturation.
    branch_condition_unit #(.WIDTH(8), .COUNT_WIDTH(2), .BYPASS(1)) dut_sat (
        .clock(clock), .reset(reset), .flags_we(flags_we),
        .operand_a(operand_a), .operand_b(operand_b), .cmp_signed(cmp_signed),
        .req_valid(req_valid), .req_opcode(req_opcode), .req_ready(rr[2]),
        .resp_valid(rv[2]), .resp_taken(rt[2]), .resp_ready(resp_ready),
        .flags_valid(fv[2]), .taken_count(tc2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model state per instance.
    bit mz [3];
    bit ml [3];
    bit mv [3];
    bit mfull [3];
    bit mtaken [3];
    int mcount [3];
    bit byp [3] = '{1'b1, 1'b0, 1'b1};
    int cmax [3] = '{65535, 65535, 3};

    // Per-cycle check of every instance, then advance the model to the next edge.
    always @(negedge clock) begin : model_check
        int ia;
        int ib;
        bit nz;
        bit nl;
        bit ez;
        bit el;
        bit ev;
        bit need;
        bit rdy;
        bit dec;
        ia = int'(operand_a);
        ib = int'(operand_b);
        if (cmp_signed) begin
            if (ia >= 128) ia = ia - 256;
            if (ib >= 128) ib = ib - 256;
        end
        nz = (ia == ib);
        nl = (ia < ib);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mz[k] = 0; ml[k] = 0; mv[k] = 0;
                mfull[k] = 0; mtaken[k] = 0; mcount[k] = 0;
            end
            ez = (byp[k] && flags_we) ? nz : mz[k];
            el = (byp[k] && flags_we) ? nl : ml[k];
            ev = (byp[k] && flags_we) ? 1'b1 : mv[k];
            need = !(req_opcode == OP_NEVER || req_opcode == OP_ALWAYS);
            rdy = (!need || ev) && (!mfull[k] || resp_ready);
            case (req_opcode)
                OP_EQ:     dec = ez;
                OP_NE:     dec = !ez;
                OP_LT:     dec = el;
                OP_GE:     dec = !el;
                OP_LE:     dec = el || ez;
                OP_GT:     dec = !el && !ez;
                OP_ALWAYS: dec = 1'b1;
                default:   dec = 1'b0;
            endcase
            chk($sformatf("req_ready[%0d]", k), 32'(rr[k]), 32'(rdy));
            chk($sformatf("resp_valid[%0d]", k), 32'(rv[k]), 32'(mfull[k]));
            chk($sformatf("flags_valid[%0d]", k), 32'(fv[k]), 32'(mv[k]));
            chk($sformatf("taken_count[%0d]", k), 32'(tcv[k]), 32'(mcount[k]));
            if (mfull[k] || reset)
                chk($sformatf("resp_taken[%0d]", k), 32'(rt[k]), 32'(mtaken[k]));
            if (!reset) begin
                if (req_valid && rdy) begin
                    mfull[k] = 1;
                    mtaken[k] = dec;
                    if (dec && mcount[k] < cmax[k]) mcount[k]++;
                end else if (mfull[k] && resp_ready) begin
                    mfull[k] = 0;
                end
                if (flags_we) begin
                    mz[k] = nz; ml[k] = nl; mv[k] = 1;
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [7:0] a, input logic [7:0] b, input logic sg,
                         input logic v, input logic [2:0] op, input logic rdy);
        flags_we = we; operand_a = a; operand_b = b; cmp_signed = sg;
        req_valid = v; req_opcode = op; resp_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 8'h00, 8'h00, 0, 0, OP_NEVER, 1);
        tick(); tick();
        reset = 1'b0;

        // Reset while FULL, then flag dependency before any flag write.
        drive(0, 8'h00, 8'h00, 0, 1, OP_ALWAYS, 0);
        tick();
        chk("fill_valid", 32'(rv[0]), 1);
        chk("fill_count", 32'(tc0), 1);
        drive(0, 8'h00, 8'h00, 0, 0, OP_NEVER, 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_resp_valid", 32'(rv[0]), 0);
        chk("rst_taken_count", 32'(tc0), 0);
        chk("rst_flags_valid", 32'(fv[0]), 0);
        tick();
        reset = 1'b0;
        drive(0, 8'h00, 8'h00, 0, 1, OP_EQ, 1);
        #1 chk("eq_no_flags_ready", 32'(rr[0]), 0);
        req_opcode = OP_ALWAYS;
        #1 chk("always_ready", 32'(rr[0]), 1);
        tick();
        chk("always_valid", 32'(rv[0]), 1);
        chk("always_taken", 32'(rt[0]), 1);

        // Signed compare 0 vs -1.
        drive(1, 8'h00, 8'hFF, 1, 0, OP_NEVER, 1);
        tick();
        drive(0, 8'h00, 8'h00, 0, 1, OP_GT, 1); tick(); chk("s_gt", 32'(rt[0]), 1);
        req_opcode = OP_LT; tick(); chk("s_lt", 32'(rt[0]), 0);
        req_opcode = OP_NE; tick(); chk("s_ne", 32'(rt[0]), 1);
        req_opcode = OP_EQ; tick(); chk("s_eq", 32'(rt[0]), 0);

        // Unsigned compare 0 vs 255.
        drive(1, 8'h00, 8'hFF, 0, 0, OP_NEVER, 1);
        tick();
        drive(0, 8'h00, 8'h00, 0, 1, OP_LT, 1); tick(); chk("u_lt", 32'(rt[0]), 1);
        req_opcode = OP_GE; tick(); chk("u_ge", 32'(rt[0]), 0);
        req_opcode = OP_LE; tick(); chk("u_le", 32'(rt[0]), 1);

        // Bypass versus registered flags.
        drive(1, 8'h01, 8'h02, 0, 0, OP_NEVER, 1);
        tick();
        drive(1, 8'h0F, 8'h0F, 0, 1, OP_EQ, 1);
        tick();
        chk("bypass_on_eq", 32'(rt[0]), 1);
        chk("bypass_off_eq", 32'(rt[1]), 0);

        // Backpressure while FULL with a taken decision.
        drive(0, 8'h00, 8'h00, 0, 1, OP_ALWAYS, 0);
        tick();
        chk("bp_fill_taken", 32'(rt[0]), 1);
        drive(0, 8'h00, 8'h00, 0, 1, OP_NEVER, 0);
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_req_ready", 32'(rr[0]), 0);
            tick();
            chk("bp_hold_taken", 32'(rt[0]), 1);
            chk("bp_hold_valid", 32'(rv[0]), 1);
        end
        resp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(rr[0]), 1);
        tick();
        chk("bp_next_valid", 32'(rv[0]), 1);
        chk("bp_next_taken", 32'(rt[0]), 0);

        // Saturation of the two-bit counter.
        drive(0, 8'h00, 8'h00, 0, 0, OP_NEVER, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 8'h00, 0, 1, OP_ALWAYS, 1);
            tick();
            chk("sat_count", 32'(tc2), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 8'h00, 8'h00, 0, 1, OP_NEVER, 1);
            tick();
            chk("sat_never_count", 32'(tc2), 3);
        end
        drive(0, 8'h00, 8'h00, 0, 0, OP_NEVER, 1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_condition_unit.md
Name: branch_condition_unit

Overview:
Registered, parametrised successor to the combinational condition evaluator. It compares two WIDTH-bit operands in signed or unsigned mode and latches Z/L flags on a flag write. It then resolves branch-condition requests through a valid/ready handshake with a one-entry output buffer. It sits between the ALU flag path and the fetch/branch control, and keeps a saturating count of taken branches.

Parameters:
WIDTH, 8, operand width in bits (>=2)
COUNT_WIDTH, 16, width of taken_count
BYPASS, 1, 1 = a request in the same cycle as flags_we sees the new flags; 0 = it sees the old flags

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
flags_we  in  1  capture flags from operand_a/operand_b this cycle
operand_a  in  WIDTH  left compare operand
operand_b  in  WIDTH  right compare operand
cmp_signed  in  1  1 = two's-complement compare, 0 = unsigned compare (sampled with flags_we)
req_valid  in  1  condition request valid
req_opcode  in  3  condition code
req_ready  out  1  request accepted when req_valid && req_ready
resp_valid  out  1  branch decision valid
resp_taken  out  1  branch decision
resp_ready  in  1  consumer accepts response
flags_valid  out  1  flags written at least once since reset
taken_count  out  COUNT_WIDTH  saturating count of taken responses issued

Behaviour:
- Opcodes (shared package): 000 NEVER, 001 EQ, 010 LT, 011 LE, 100 ALWAYS, 101 NE, 110 GT, 111 GE.
- Opcode semantics: NEVER=0; ALWAYS=1; EQ=Z; NE=!Z; LT=L; LE=L|Z; GT=!(L|Z); GE=!L.
- Flag capture, on a flags_we edge:
  - Z <= (operand_a == operand_b).
  - L <= (a<b), signed or unsigned per cmp_signed.
  - flags_valid <= 1.
- Effective flags: if BYPASS=1 and flags_we=1 in the current cycle, use the combinationally computed new Z/L/valid; otherwise use the registered values.
- Flag dependency: an opcode with req_opcode[1:0]!=00 needs effective flags_valid=1. NEVER/ALWAYS never need flags.
- req_ready = (flag dependency satisfied) && (!resp_valid || resp_ready).
  - req_ready depends combinationally on req_opcode. The requester must not make req_valid depend on req_ready.
- Output buffer, 2 states:
  - EMPTY (resp_valid=0) -> FULL on acceptance. Latency is 1 cycle: resp_valid and resp_taken are registered at the edge that accepts the request.
  - FULL -> EMPTY when resp_ready=1 and no new acceptance that cycle.
  - FULL with resp_ready=1 and a new acceptance: stays FULL and loads the new decision (back-to-back throughput of 1 per cycle).
  - FULL with resp_ready=0: resp_taken holds stable, req_ready=0.
- taken_count increments on the edge that loads a taken decision into the buffer. It saturates at all-ones and never wraps.
- Flags never change a response that is already buffered.
- Reset, asynchronous, any time including while FULL:
  - resp_valid=0, resp_taken=0, Z=0, L=0, flags_valid=0, taken_count=0, state EMPTY.
  - The in-flight response is discarded.
- Width rules:
  - Signed compare uses $signed on both operands.
  - Unsigned compare is a plain WIDTH-bit compare.
  - No extension beyond WIDTH.

Decomposition:
- Package branch_condition_pkg holds:
  - cond_opcode_t, a 3-bit enum with the eight codes;
  - function cond_eval(opcode, Z, L).
- The enum is shared with the decoder.
- Sub-module branch_flag_compare (WIDTH): combinational Z/L from the operands and cmp_signed. Instantiated once, feeding both the flag register and the bypass path.
- Buffer, counter and handshake stay in the top module.

Test Plan:
1. Reset: assert reset mid-FULL -> resp_valid=0, taken_count=0, flags_valid=0 immediately. Then EQ with req_valid=1 -> req_ready=0; ALWAYS -> req_ready=1, resp_taken=1 one cycle later.
2. Signed compare, WIDTH=8: flags_we with a=8'h00, b=8'hFF, cmp_signed=1. Then GT -> taken=1, LT -> 0, NE -> 1, EQ -> 0.
3. Unsigned compare: the same operands with cmp_signed=0 -> LT=1, GE=0, LE=1.
4. Bypass: BYPASS=1, flags_we with a=b=8'h0F in the same cycle as an EQ request -> resp_taken=1. With BYPASS=0 and prior flags from a=1, b=2, the same stimulus -> resp_taken=0.
5. Backpressure: resp_ready=0 with FULL (taken=1) -> resp_taken stable for 5 cycles, req_ready=0. Release resp_ready together with a NEVER request -> the next cycle holds taken=0, with no bubble.
6. Saturation: COUNT_WIDTH=2, five ALWAYS responses drained back-to-back -> taken_count sequence 1,2,3,3,3. NEVER responses leave it unchanged.
